// File: rtl/iq_stream_packer.sv
// I/Q stream joiner: per-lane FIFOs feeding a registered AXI-stream output of packed IQ words,
// with selectable lane order, flush, sticky lane-skew flag and an output sample counter.

module iq_lane_fifo #(
    parameter int W     = 16,
    parameter int DEPTH = 4
) (
    input  logic         samp_clk,
    input  logic         samp_rst_n,
    input  logic         flush,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;

    always_ff @(posedge samp_clk or negedge samp_rst_n) begin
        if (!samp_rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
        end
    end

    // Storage needs no reset; occupancy alone decides what is valid.
    always_ff @(posedge samp_clk) begin
        if (push) mem[wr_ptr] <= din;
    end

    assign dout  = mem[rd_ptr];
    assign full  = (count == FULL_CNT);
    assign empty = (count == '0);
endmodule

module iq_stream_packer #(
    parameter int IorQ_BW = 16,
    parameter int DEPTH   = 4,
    parameter int CNT_BW  = 32
) (
    input  logic                 samp_clk,
    input  logic                 samp_rst_n,
    input  logic [IorQ_BW-1:0]   i_in_TDATA,
    input  logic                 i_in_TVALID,
    output logic                 i_in_TREADY,
    input  logic [IorQ_BW-1:0]   q_in_TDATA,
    input  logic                 q_in_TVALID,
    output logic                 q_in_TREADY,
    output logic [2*IorQ_BW-1:0] iq_out_TDATA,
    output logic                 iq_out_TVALID,
    input  logic                 iq_out_TREADY,
    input  logic                 iq_order,
    input  logic                 flush,
    input  logic                 skew_clr,
    output logic                 skew_err,
    output logic [CNT_BW-1:0]    sample_count
);
    logic [IorQ_BW-1:0]   i_head;
    logic [IorQ_BW-1:0]   q_head;
    logic                 full_i, empty_i, full_q, empty_q;
    logic                 push_i, push_q, load, skew_set;
    logic                 out_vld;
    logic [2*IorQ_BW-1:0] out_data;

    // Ready ignores the output side so no combinational path runs upstream from iq_out_TREADY.
    assign i_in_TREADY = samp_rst_n & !full_i & !flush;
    assign q_in_TREADY = samp_rst_n & !full_q & !flush;
    assign push_i      = i_in_TVALID & i_in_TREADY;
    assign push_q      = q_in_TVALID & q_in_TREADY;
    assign load        = !empty_i & !empty_q & (!out_vld | iq_out_TREADY) & !flush;
    assign skew_set    = (full_i & empty_q) | (full_q & empty_i);

    iq_lane_fifo #(.W(IorQ_BW), .DEPTH(DEPTH)) u_fifo_i (
        .samp_clk   (samp_clk),
        .samp_rst_n (samp_rst_n),
        .flush      (flush),
        .push       (push_i),
        .din        (i_in_TDATA),
        .pop        (load),
        .dout       (i_head),
        .full       (full_i),
        .empty      (empty_i)
    );

    iq_lane_fifo #(.W(IorQ_BW), .DEPTH(DEPTH)) u_fifo_q (
        .samp_clk   (samp_clk),
        .samp_rst_n (samp_rst_n),
        .flush      (flush),
        .push       (push_q),
        .din        (q_in_TDATA),
        .pop        (load),
        .dout       (q_head),
        .full       (full_q),
        .empty      (empty_q)
    );

    always_ff @(posedge samp_clk or negedge samp_rst_n) begin
        if (!samp_rst_n) begin
            out_vld  <= 1'b0;
            out_data <= '0;
        end else if (flush) begin
            out_vld  <= 1'b0;
        end else if (load) begin
            out_vld  <= 1'b1;
            out_data <= iq_order ? {q_head, i_head} : {i_head, q_head};
        end else if (iq_out_TREADY) begin
            out_vld  <= 1'b0;
        end
    end

    always_ff @(posedge samp_clk or negedge samp_rst_n) begin
        if (!samp_rst_n) begin
            skew_err     <= 1'b0;
            sample_count <= '0;
        end else begin
            if (skew_set)      skew_err <= 1'b1;
            else if (skew_clr) skew_err <= 1'b0;
            if (out_vld && iq_out_TREADY) sample_count <= sample_count + 1'b1;
        end
    end

    assign iq_out_TVALID = out_vld;
    assign iq_out_TDATA  = out_vld ? out_data : '0;
endmodule

// File: tb/tb_iq_stream_packer.sv
// Directed bench for iq_stream_packer: vector table for join/order streaming,
// hand-written sequences for skew, stall, flush and asynchronous reset.

module tb_iq_stream_packer;
    logic        samp_clk = 1'b0;
    logic        samp_rst_n;
    logic [15:0] i_in_TDATA, q_in_TDATA;
    logic        i_in_TVALID, q_in_TVALID;
    logic        i_in_TREADY, q_in_TREADY;
    logic [31:0] iq_out_TDATA;
    logic        iq_out_TVALID, iq_out_TREADY;
    logic        iq_order, flush, skew_clr, skew_err;
    logic [31:0] sample_count;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [15:0] i_d;
        logic        i_v;
        logic [15:0] q_d;
        logic        q_v;
        logic        ord;
        logic        o_rdy;
        logic [31:0] e_data;
        logic        e_vld;
        logic [31:0] e_cnt;
    } vec_t;

    vec_t vecs[$];

    iq_stream_packer #(.IorQ_BW(16), .DEPTH(4), .CNT_BW(32)) dut (
        .samp_clk      (samp_clk),
        .samp_rst_n    (samp_rst_n),
        .i_in_TDATA    (i_in_TDATA),
        .i_in_TVALID   (i_in_TVALID),
        .i_in_TREADY   (i_in_TREADY),
        .q_in_TDATA    (q_in_TDATA),
        .q_in_TVALID   (q_in_TVALID),
        .q_in_TREADY   (q_in_TREADY),
        .iq_out_TDATA  (iq_out_TDATA),
        .iq_out_TVALID (iq_out_TVALID),
        .iq_out_TREADY (iq_out_TREADY),
        .iq_order      (iq_order),
        .flush         (flush),
        .skew_clr      (skew_clr),
        .skew_err      (skew_err),
        .sample_count  (sample_count)
    );

    always #5 samp_clk = ~samp_clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge samp_clk);
        #1;
    endtask

    function automatic vec_t mkv(input logic [15:0] id, input logic iv, input logic [15:0] qd,
                                 input logic qv, input logic ord, input logic rdy,
                                 input logic [31:0] ed, input logic ev, input logic [31:0] ec);
        vec_t v;
        v.i_d = id; v.i_v = iv; v.q_d = qd; v.q_v = qv; v.ord = ord; v.o_rdy = rdy;
        v.e_data = ed; v.e_vld = ev; v.e_cnt = ec;
        return v;
    endfunction

    initial begin
        int idx;
        int got;
        logic rdy_both;

        // Basic join: accepted on first edge, visible after the second, counted after the third.
        vecs.push_back(mkv(16'h1111, 1, 16'h2222, 1, 0, 1, 32'h0,        0, 0));
        vecs.push_back(mkv(16'h0,    0, 16'h0,    0, 0, 1, 32'h11112222, 1, 0));
        vecs.push_back(mkv(16'h0,    0, 16'h0,    0, 0, 1, 32'h0,        0, 1));
        // Eight back-to-back pairs with {Q,I} ordering.
        vecs.push_back(mkv(16'h0, 1, 16'h100, 1, 1, 1, 32'h0, 0, 1));
        for (int k = 1; k < 8; k++)
            vecs.push_back(mkv(16'(k), 1, 16'(32'h100 + k), 1, 1, 1,
                               {16'(32'h100 + k - 1), 16'(k - 1)}, 1, 32'(k)));
        vecs.push_back(mkv(16'h0, 0, 16'h0, 0, 1, 1, {16'h107, 16'h7}, 1, 8));
        vecs.push_back(mkv(16'h0, 0, 16'h0, 0, 1, 1, 32'h0, 0, 9));

        samp_rst_n = 1'b0;
        i_in_TDATA = '0; q_in_TDATA = '0; i_in_TVALID = 0; q_in_TVALID = 0;
        iq_out_TREADY = 0; iq_order = 0; flush = 0; skew_clr = 0;
        #2;
        chk("rst_vld", iq_out_TVALID, 0);
        chk("rst_data", iq_out_TDATA, 0);
        chk("rst_irdy", i_in_TREADY, 0);
        chk("rst_qrdy", q_in_TREADY, 0);
        chk("rst_cnt", sample_count, 0);
        chk("rst_skew", skew_err, 0);
        repeat (2) @(posedge samp_clk);
        #1 samp_rst_n = 1'b1;
        #1;
        chk("rel_irdy", i_in_TREADY, 1);
        chk("rel_qrdy", q_in_TREADY, 1);

        foreach (vecs[n]) begin
            i_in_TDATA = vecs[n].i_d; i_in_TVALID = vecs[n].i_v;
            q_in_TDATA = vecs[n].q_d; q_in_TVALID = vecs[n].q_v;
            iq_order = vecs[n].ord; iq_out_TREADY = vecs[n].o_rdy;
            step();
            chk($sformatf("vec%0d_vld", n), iq_out_TVALID, vecs[n].e_vld);
            chk($sformatf("vec%0d_data", n), iq_out_TDATA, vecs[n].e_data);
            chk($sformatf("vec%0d_cnt", n), sample_count, vecs[n].e_cnt);
            chk($sformatf("vec%0d_rdy", n), {i_in_TREADY, q_in_TREADY}, 2'b11);
        end

        // Skew: fill I with Q idle, then let Q catch up.
        iq_order = 0; iq_out_TREADY = 1;
        for (int k = 0; k < 4; k++) begin
            i_in_TVALID = 1; i_in_TDATA = 16'(32'hA0 + k);
            step();
            chk($sformatf("skew_irdy%0d", k), i_in_TREADY, (k < 3));
        end
        i_in_TVALID = 0;
        chk("skew_not_yet", skew_err, 0);
        step();
        chk("skew_set", skew_err, 1);
        chk("skew_no_out", iq_out_TVALID, 0);
        for (int j = 0; j < 6; j++) begin
            q_in_TVALID = (j < 4); q_in_TDATA = 16'(32'hB0 + j);
            step();
            if (j >= 1 && j <= 4) begin
                chk($sformatf("skew_word%0d", j - 1), iq_out_TDATA,
                    {16'(32'hA0 + j - 1), 16'(32'hB0 + j - 1)});
                chk($sformatf("skew_vld%0d", j - 1), iq_out_TVALID, 1);
            end
        end
        q_in_TVALID = 0;
        chk("skew_end_vld", iq_out_TVALID, 0);
        chk("skew_cnt", sample_count, 13);
        chk("skew_sticky", skew_err, 1);
        skew_clr = 1;
        step();
        skew_clr = 0;
        chk("skew_clr", skew_err, 0);

        // Output stall: both lanes stream into a blocked output.
        iq_out_TREADY = 0;
        idx = 0;
        for (int c = 0; c < 10; c++) begin
            rdy_both = i_in_TREADY & q_in_TREADY;
            i_in_TVALID = 1; q_in_TVALID = 1;
            i_in_TDATA = 16'(32'hC0 + idx); q_in_TDATA = 16'(32'hD0 + idx);
            step();
            if (rdy_both) idx++;
            if (c >= 1) chk($sformatf("stall_hold%0d", c), {iq_out_TVALID, iq_out_TDATA},
                            {1'b1, 16'hC0, 16'hD0});
        end
        chk("stall_pushes", idx, 5);
        chk("stall_rdy", {i_in_TREADY, q_in_TREADY}, 2'b00);
        chk("stall_cnt", sample_count, 13);
        i_in_TVALID = 0; q_in_TVALID = 0; iq_out_TREADY = 1;
        got = 0;
        for (int t = 0; t < 20 && got < idx; t++) begin
            if (iq_out_TVALID) begin
                chk($sformatf("drain%0d", got), iq_out_TDATA, {16'(32'hC0 + got), 16'(32'hD0 + got)});
                got++;
            end
            step();
        end
        chk("drain_got", got, 5);
        chk("drain_vld", iq_out_TVALID, 0);
        chk("drain_cnt", sample_count, 18);

        // Flush with three pairs buffered and a word held in the output register.
        iq_out_TREADY = 0;
        for (int k = 0; k < 4; k++) begin
            i_in_TVALID = 1; q_in_TVALID = 1;
            i_in_TDATA = 16'(32'hE0 + k); q_in_TDATA = 16'(32'hF0 + k);
            step();
        end
        i_in_TVALID = 0; q_in_TVALID = 0;
        chk("fl_pre", {iq_out_TVALID, iq_out_TDATA}, {1'b1, 16'hE0, 16'hF0});
        flush = 1;
        step();
        chk("fl_vld", iq_out_TVALID, 0);
        chk("fl_data", iq_out_TDATA, 0);
        chk("fl_rdy_during", {i_in_TREADY, q_in_TREADY}, 2'b00);
        chk("fl_cnt", sample_count, 18);
        flush = 0;
        #1;
        chk("fl_rdy_after", {i_in_TREADY, q_in_TREADY}, 2'b11);
        iq_out_TREADY = 1;
        repeat (3) step();
        chk("fl_empty", iq_out_TVALID, 0);
        chk("fl_cnt2", sample_count, 18);

        // Asynchronous reset mid-stream with skew_err set and a word pending.
        iq_out_TREADY = 0;
        for (int k = 0; k < 4; k++) begin
            i_in_TVALID = 1; i_in_TDATA = 16'(32'h50 + k);
            step();
        end
        i_in_TVALID = 0;
        step();
        chk("ar_skew", skew_err, 1);
        q_in_TVALID = 1; q_in_TDATA = 16'h99;
        step();
        q_in_TVALID = 0;
        step();
        chk("ar_pre", {iq_out_TVALID, iq_out_TDATA}, {1'b1, 16'h50, 16'h99});
        #3 samp_rst_n = 1'b0;
        #1;
        chk("ar_vld", iq_out_TVALID, 0);
        chk("ar_data", iq_out_TDATA, 0);
        chk("ar_cnt", sample_count, 0);
        chk("ar_skew0", skew_err, 0);
        chk("ar_rdy", {i_in_TREADY, q_in_TREADY}, 2'b00);
        step();
        chk("ar_rdy_hold", {i_in_TREADY, q_in_TREADY}, 2'b00);
        samp_rst_n = 1'b1;
        #1;
        chk("ar_rdy_rel", {i_in_TREADY, q_in_TREADY}, 2'b11);
        iq_out_TREADY = 1;
        i_in_TVALID = 1; q_in_TVALID = 1; i_in_TDATA = 16'h1234; q_in_TDATA = 16'h5678;
        step();
        i_in_TVALID = 0; q_in_TVALID = 0;
        chk("ar_join0", iq_out_TVALID, 0);
        step();
        chk("ar_join1", {iq_out_TVALID, iq_out_TDATA}, {1'b1, 32'h12345678});
        step();
        chk("ar_join_cnt", sample_count, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
